// File: rtl/serdes_link_seq_if.sv
// Lane-side signal bundle between the bring-up sequencer and one CC_SERDES lane.
// The master modport is the sequencer; the slave modport is the lane or its model.
interface serdes_link_seq_if;
  logic        start_i;
  logic        pll_rst_o;
  logic        trx_rst_o;
  logic        tx_reset_done_i;
  logic        rx_reset_done_i;
  logic        rx_byte_aligned_i;
  logic [63:0] rx_data_i;
  logic [7:0]  rx_char_is_k_i;
  logic [7:0]  rx_not_in_table_i;
  logic [63:0] tx_data_o;
  logic [7:0]  tx_char_is_k_o;
  logic        comma_align_en_o;
  logic        link_up_o;
  logic        fault_o;
  logic [2:0]  state_o;
  logic [3:0]  retry_cnt_o;
  logic [15:0] err_cnt_o;

  modport master (
    input  start_i, tx_reset_done_i, rx_reset_done_i, rx_byte_aligned_i,
           rx_data_i, rx_char_is_k_i, rx_not_in_table_i,
    output pll_rst_o, trx_rst_o, tx_data_o, tx_char_is_k_o, comma_align_en_o,
           link_up_o, fault_o, state_o, retry_cnt_o, err_cnt_o
  );

  modport slave (
    output start_i, tx_reset_done_i, rx_reset_done_i, rx_byte_aligned_i,
           rx_data_i, rx_char_is_k_i, rx_not_in_table_i,
    input  pll_rst_o, trx_rst_o, tx_data_o, tx_char_is_k_o, comma_align_en_o,
           link_up_o, fault_o, state_o, retry_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/serdes_link_seq.sv
// Bring-up sequencer and loopback link checker for one CC_SERDES lane:
// PLL/TRX reset, comma alignment, training-pattern check, bounded retry.
module serdes_link_seq #(
  parameter int PLL_RST_CYCLES = 256,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ALIGN_GOOD     = 16,
  parameter int TRAIN_GOOD     = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int K_POS          = 1
) (
  input  logic              ref_clk,
  input  logic              rstn_i,
  serdes_link_seq_if.master lnk
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLL_RST = 3'd1;
  localparam logic [2:0] S_TRX_RST = 3'd2;
  localparam logic [2:0] S_ALIGN   = 3'd3;
  localparam logic [2:0] S_TRAIN   = 3'd4;
  localparam logic [2:0] S_LINK_UP = 3'd5;
  localparam logic [2:0] S_FAULT   = 3'd6;

  localparam logic [19:0] PLL_LAST   = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_GOOD - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_GOOD - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);
  localparam logic [7:0]  K_MASK     = 8'(1 << K_POS);

  function automatic logic [63:0] comma_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = (i == K_POS) ? 8'hBC : 8'h4A;
    return w;
  endfunction

  function automatic logic [63:0] pattern(input logic [7:0] seq);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = seq + 8'(i);
    return w;
  endfunction

  localparam logic [63:0] COMMA = comma_word();

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ref_clk or negedge rstn_i) begin
    if (!rstn_i) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [2:0]  state, nxt;
  logic [19:0] cnt, nxt_cnt;
  logic [15:0] run;
  logic        seeded;
  logic [7:0]  rseq;
  logic [7:0]  tx_seq;
  logic [3:0]  retry_cnt;
  logic [15:0] err_cnt;
  logic        pll_rst, trx_rst, comma_align_en, link_up, fault;
  logic [63:0] tx_data;
  logic [7:0]  tx_char_is_k;

  logic align_good, seed_ok, word_match, timeout, do_retry, done_both, in_pattern;

  always_comb begin
    done_both  = lnk.tx_reset_done_i && lnk.rx_reset_done_i;
    align_good = lnk.rx_byte_aligned_i && (lnk.rx_char_is_k_i == K_MASK) &&
                 (lnk.rx_not_in_table_i == 8'h00);
    seed_ok    = (lnk.rx_data_i[7:0] != 8'h4A) && (lnk.rx_char_is_k_i == 8'h00);
    word_match = seeded && (lnk.rx_data_i == pattern(rseq)) &&
                 (lnk.rx_char_is_k_i == 8'h00) && (lnk.rx_not_in_table_i == 8'h00);
    timeout    = (cnt == TMO_LAST);
    in_pattern = (state == S_TRAIN) || (state == S_LINK_UP);
    do_retry   = 1'b0;
    nxt        = state;
    // Success is tested before the timeout so it wins on a tie.
    case (state)
      S_IDLE:    if (lnk.start_i) nxt = S_PLL_RST;
      S_PLL_RST: if (cnt == PLL_LAST) nxt = S_TRX_RST;
      S_TRX_RST: if (done_both) nxt = S_ALIGN;
                 else if (timeout) do_retry = 1'b1;
      S_ALIGN:   if (align_good && run == ALIGN_LAST) nxt = S_TRAIN;
                 else if (timeout) do_retry = 1'b1;
      S_TRAIN:   if (word_match && run == TRAIN_LAST) nxt = S_LINK_UP;
                 else if (timeout) do_retry = 1'b1;
      S_LINK_UP: if (!lnk.rx_byte_aligned_i || !done_both) do_retry = 1'b1;
      S_FAULT:   nxt = S_FAULT;
      default:   nxt = S_IDLE;
    endcase
    if (do_retry) nxt = (retry_cnt < RETRY_MAX) ? S_PLL_RST : S_FAULT;
    if (!lnk.start_i) nxt = S_IDLE;
    if (nxt != state)          nxt_cnt = 20'd0;
    else if (cnt == 20'hFFFFF) nxt_cnt = cnt;
    else                       nxt_cnt = cnt + 20'd1;
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= 20'd0;
      run            <= 16'd0;
      seeded         <= 1'b0;
      retry_cnt      <= 4'd0;
      err_cnt        <= 16'd0;
      pll_rst        <= 1'b1;
      trx_rst        <= 1'b1;
      comma_align_en <= 1'b0;
      link_up        <= 1'b0;
      fault          <= 1'b0;
      tx_data        <= COMMA;
      tx_char_is_k   <= K_MASK;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;

      if (nxt != state)                        run <= 16'd0;
      else if (state == S_ALIGN)               run <= align_good ? run + 16'd1 : 16'd0;
      else if (in_pattern && !word_match)      run <= 16'd0;
      else if (in_pattern && run != 16'hFFFF)  run <= run + 16'd1;

      if (!in_pattern)      seeded <= 1'b0;
      else if (!word_match) seeded <= seed_ok;

      if (state == S_IDLE && nxt == S_PLL_RST)       retry_cnt <= 4'd0;
      else if (do_retry && nxt == S_PLL_RST && retry_cnt != 4'hF)
                                                     retry_cnt <= retry_cnt + 4'd1;

      if (state == S_IDLE && nxt == S_PLL_RST) err_cnt <= 16'd0;
      else if (state == S_LINK_UP && seeded && !word_match && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;

      // Outputs follow the next state so they change together with state_o.
      pll_rst        <= (nxt == S_IDLE) || (nxt == S_PLL_RST) || (nxt == S_FAULT);
      trx_rst        <= (nxt == S_IDLE) || (nxt == S_PLL_RST) || (nxt == S_FAULT) ||
                        ((nxt == S_TRX_RST) && (nxt_cnt < 20'd16));
      comma_align_en <= (nxt == S_ALIGN);
      link_up        <= (nxt == S_LINK_UP);
      fault          <= (nxt == S_FAULT);

      if (nxt == S_TRAIN || nxt == S_LINK_UP) begin
        tx_char_is_k <= 8'h00;
        tx_data      <= in_pattern ? pattern(tx_seq) : pattern(8'd0);
      end else begin
        tx_char_is_k <= K_MASK;
        tx_data      <= COMMA;
      end
    end
  end

  // Pattern sequence registers carry no control meaning and need no reset.
  always_ff @(posedge ref_clk) begin
    if (nxt == S_TRAIN || nxt == S_LINK_UP) tx_seq <= in_pattern ? tx_seq + 8'd8 : 8'd8;
    else                                    tx_seq <= 8'd0;

    if (!in_pattern)     rseq <= 8'd0;
    else if (word_match) rseq <= rseq + 8'd8;
    else if (seed_ok)    rseq <= lnk.rx_data_i[7:0] + 8'd8;
  end

  assign lnk.pll_rst_o        = pll_rst;
  assign lnk.trx_rst_o        = trx_rst;
  assign lnk.tx_data_o        = tx_data;
  assign lnk.tx_char_is_k_o   = tx_char_is_k;
  assign lnk.comma_align_en_o = comma_align_en;
  assign lnk.link_up_o        = link_up;
  assign lnk.fault_o          = fault;
  assign lnk.state_o          = state;
  assign lnk.retry_cnt_o      = retry_cnt;
  assign lnk.err_cnt_o        = err_cnt;

endmodule
